// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_sequencer
// Purpose  : One-request-at-a-time front end for the 512-byte RAM; splits
//            LDD/STD/SWAP into two word accesses and rejects bad requests.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_sequencer #(
  parameter int MEM_BYTES   = 512,
  parameter int MFC_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic [5:0]  Op,
  input  logic [31:0] Addr,
  input  logic [63:0] WrData,
  output logic [63:0] RdData,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic        Enable,
  output logic [5:0]  OpCode,
  output logic [31:0] MAR_Address,
  output logic [31:0] MDR_DataIn,
  input  logic [31:0] MDR_DataOut,
  input  logic        MFC
);

  localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);

  localparam logic [5:0] c_OP_LD   = 6'b000000;
  localparam logic [5:0] c_OP_LDUB = 6'b000001;
  localparam logic [5:0] c_OP_LDUH = 6'b000010;
  localparam logic [5:0] c_OP_LDD  = 6'b000011;
  localparam logic [5:0] c_OP_ST   = 6'b000100;
  localparam logic [5:0] c_OP_STB  = 6'b000101;
  localparam logic [5:0] c_OP_STH  = 6'b000110;
  localparam logic [5:0] c_OP_STD  = 6'b000111;
  localparam logic [5:0] c_OP_LDSB = 6'b001001;
  localparam logic [5:0] c_OP_LDSH = 6'b001010;
  localparam logic [5:0] c_OP_SWAP = 6'b001111;

  localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(MFC_TIMEOUT - 1);
  localparam logic [32:0]      c_MEM_LIMIT = 33'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] din;
  } drive_t;

  // Access size in bytes; zero marks an opcode the RAM does not support.
  function automatic logic [3:0] op_size(input logic [5:0] op);
    case (op)
      c_OP_LDUB, c_OP_STB, c_OP_LDSB: op_size = 4'd1;
      c_OP_LDUH, c_OP_STH, c_OP_LDSH: op_size = 4'd2;
      c_OP_LD,   c_OP_ST,  c_OP_SWAP: op_size = 4'd4;
      c_OP_LDD,  c_OP_STD:            op_size = 4'd8;
      default:                        op_size = 4'd0;
    endcase
  endfunction

  function automatic logic is_single_load(input logic [5:0] op);
    case (op)
      c_OP_LD, c_OP_LDUB, c_OP_LDUH, c_OP_LDSB, c_OP_LDSH: is_single_load = 1'b1;
      default:                                             is_single_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_two_access(input logic [5:0] op);
    is_two_access = (op == c_OP_LDD) || (op == c_OP_STD) || (op == c_OP_SWAP);
  endfunction

  // RAM-side opcode/address/data for one phase of a request.
  function automatic drive_t phase_drive(input logic [5:0]  op,
                                         input logic [31:0] addr,
                                         input logic [63:0] wd,
                                         input logic        ph);
    drive_t d;
    d.op   = op;
    d.addr = addr;
    d.din  = wd[31:0];
    case (op)
      c_OP_LDD: begin
        d.op   = c_OP_LD;
        d.addr = ph ? (addr + 32'd4) : addr;
      end
      c_OP_STD: begin
        d.op   = c_OP_ST;
        d.addr = ph ? (addr + 32'd4) : addr;
        d.din  = ph ? wd[31:0] : wd[63:32];
      end
      c_OP_SWAP: begin
        d.op = ph ? c_OP_ST : c_OP_LD;
      end
      default: ;
    endcase
    return d;
  endfunction

  state_t          r_state, w_state_nxt;
  logic            r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_cnt,  w_cnt_nxt;
  logic [5:0]      r_op,     w_op_nxt;
  logic [31:0]     r_addr,   w_addr_nxt;
  logic [63:0]     r_wdata,  w_wdata_nxt;
  logic [31:0]     r_word0,  w_word0_nxt;
  logic            r_enable, w_enable_nxt;
  logic [5:0]      r_opcode, w_opcode_nxt;
  logic [31:0]     r_mar,    w_mar_nxt;
  logic [31:0]     r_mdr_in, w_mdr_nxt;
  logic [63:0]     r_rddata, w_rd_nxt;
  logic            r_done,   w_done_nxt;
  logic            r_err,    w_err_nxt;

  logic [3:0]  w_size;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_range;
  logic        w_reject;
  drive_t      w_drv;

  assign w_size    = op_size(Op);
  assign w_illegal = (w_size == 4'd0);

  always_comb begin
    w_misalign = 1'b0;
    case (w_size)
      4'd2:    w_misalign = Addr[0];
      4'd4:    w_misalign = (Addr[1:0] != 2'b00);
      4'd8:    w_misalign = (Addr[2:0] != 3'b000);
      default: w_misalign = 1'b0;
    endcase
  end

  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign w_range  = (({1'b0, Addr} + {29'd0, w_size}) > c_MEM_LIMIT);
  assign w_reject = w_illegal | w_misalign | w_range;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_phase  <= 1'b0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word0  <= '0;
      r_enable <= 1'b0;
      r_opcode <= '0;
      r_mar    <= '0;
      r_mdr_in <= '0;
      r_rddata <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_word0  <= w_word0_nxt;
      r_enable <= w_enable_nxt;
      r_opcode <= w_opcode_nxt;
      r_mar    <= w_mar_nxt;
      r_mdr_in <= w_mdr_nxt;
      r_rddata <= w_rd_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_word0_nxt  = r_word0;
    w_enable_nxt = r_enable;
    w_opcode_nxt = r_opcode;
    w_mar_nxt    = r_mar;
    w_mdr_nxt    = r_mdr_in;
    w_rd_nxt     = r_rddata;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_drv        = phase_drive(Op, Addr, WrData, 1'b0);

    case (r_state)
      S_IDLE: begin
        if (Req) begin
          w_op_nxt    = Op;
          w_addr_nxt  = Addr;
          w_wdata_nxt = WrData;
          if (w_reject) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end else begin
            w_state_nxt  = S_ISSUE;
            w_phase_nxt  = 1'b0;
            w_cnt_nxt    = '0;
            w_enable_nxt = 1'b1;
            w_opcode_nxt = w_drv.op;
            w_mar_nxt    = w_drv.addr;
            w_mdr_nxt    = w_drv.din;
          end
        end
      end

      S_ISSUE: begin
        if (MFC) begin
          // RAM data is only valid while Enable is high, so capture it now.
          w_enable_nxt = 1'b0;
          if (!r_phase && is_two_access(r_op)) begin
            w_word0_nxt = MDR_DataOut;
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            if (r_op == c_OP_LDD)
              w_rd_nxt = {r_word0, MDR_DataOut};
            else if (r_op == c_OP_SWAP)
              w_rd_nxt = {32'h0, r_word0};
            else if (is_single_load(r_op))
              w_rd_nxt = {32'h0, MDR_DataOut};
          end
        end else if (r_cnt == c_CNT_LAST) begin
          w_enable_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
          w_done_nxt   = 1'b1;
          w_err_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_GAP: begin
        // One Enable-low cycle lets the RAM drop MFC before phase 1.
        w_drv        = phase_drive(r_op, r_addr, r_wdata, 1'b1);
        w_state_nxt  = S_ISSUE;
        w_phase_nxt  = 1'b1;
        w_cnt_nxt    = '0;
        w_enable_nxt = 1'b1;
        w_opcode_nxt = w_drv.op;
        w_mar_nxt    = w_drv.addr;
        w_mdr_nxt    = w_drv.din;
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_enable_nxt = 1'b0;
      end
    endcase
  end

  assign Busy        = (r_state != S_IDLE);
  assign Done        = r_done;
  assign Err         = r_err;
  assign Enable      = r_enable;
  assign OpCode      = r_opcode;
  assign MAR_Address = r_mar;
  assign MDR_DataIn  = r_mdr_in;
  assign RdData      = r_rddata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_sequencer
// Purpose  : Directed bench with a byte-array RAM model and a Done scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

  localparam int MEM_BYTES   = 512;
  localparam int MFC_TIMEOUT = 16;

  localparam logic [5:0] c_LD   = 6'b000000;
  localparam logic [5:0] c_LDUB = 6'b000001;
  localparam logic [5:0] c_LDUH = 6'b000010;
  localparam logic [5:0] c_LDD  = 6'b000011;
  localparam logic [5:0] c_ST   = 6'b000100;
  localparam logic [5:0] c_STB  = 6'b000101;
  localparam logic [5:0] c_STH  = 6'b000110;
  localparam logic [5:0] c_STD  = 6'b000111;
  localparam logic [5:0] c_LDSB = 6'b001001;
  localparam logic [5:0] c_LDSH = 6'b001010;
  localparam logic [5:0] c_SWAP = 6'b001111;
  localparam logic [5:0] c_BAD  = 6'b001100;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic [5:0]  Op = '0;
  logic [31:0] Addr = '0;
  logic [63:0] WrData = '0;
  logic [63:0] RdData;
  logic        Busy, Done, Err, Enable;
  logic [5:0]  OpCode;
  logic [31:0] MAR_Address, MDR_DataIn;
  logic [31:0] MDR_DataOut;
  logic        MFC;

  always #5 Clk = ~Clk;

  mem_access_sequencer #(.MEM_BYTES(MEM_BYTES), .MFC_TIMEOUT(MFC_TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr), .WrData(WrData),
    .RdData(RdData), .Busy(Busy), .Done(Done), .Err(Err), .Enable(Enable),
    .OpCode(OpCode), .MAR_Address(MAR_Address), .MDR_DataIn(MDR_DataIn),
    .MDR_DataOut(MDR_DataOut), .MFC(MFC)
  );

  // ---------------- RAM model (big-endian bytes) ----------------
  logic [7:0]  mem [0:MEM_BYTES-1];
  int          ram_lat  = 0;
  logic        mfc_tie0 = 1'b0;
  int          ram_cnt  = 0;
  logic        bd_we    = 1'b0;
  logic [8:0]  bd_addr  = '0;
  logic [31:0] bd_data  = '0;
  logic [8:0]  ra;
  logic [7:0]  rb0, rb1, rb2, rb3;

  assign ra  = 9'(MAR_Address);
  assign MFC = Enable && !mfc_tie0 && (ram_cnt >= ram_lat);

  always @(posedge Clk) begin
    if (!Enable) ram_cnt <= 0;
    else         ram_cnt <= ram_cnt + 1;
  end

  always @(posedge Clk) begin
    if (bd_we) begin
      mem[bd_addr]         <= bd_data[31:24];
      mem[bd_addr + 9'd1]  <= bd_data[23:16];
      mem[bd_addr + 9'd2]  <= bd_data[15:8];
      mem[bd_addr + 9'd3]  <= bd_data[7:0];
    end else if (Enable && MFC) begin
      case (OpCode)
        c_ST: begin
          mem[ra]        <= MDR_DataIn[31:24];
          mem[ra + 9'd1] <= MDR_DataIn[23:16];
          mem[ra + 9'd2] <= MDR_DataIn[15:8];
          mem[ra + 9'd3] <= MDR_DataIn[7:0];
        end
        c_STH: begin
          mem[ra]        <= MDR_DataIn[15:8];
          mem[ra + 9'd1] <= MDR_DataIn[7:0];
        end
        c_STB:   mem[ra] <= MDR_DataIn[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rb0 = mem[ra];
    rb1 = mem[ra + 9'd1];
    rb2 = mem[ra + 9'd2];
    rb3 = mem[ra + 9'd3];
    MDR_DataOut = 32'h0;
    if (Enable) begin
      case (OpCode)
        c_LD:    MDR_DataOut = {rb0, rb1, rb2, rb3};
        c_LDUB:  MDR_DataOut = {24'h0, rb0};
        c_LDSB:  MDR_DataOut = {{24{rb0[7]}}, rb0};
        c_LDUH:  MDR_DataOut = {16'h0, rb0, rb1};
        c_LDSH:  MDR_DataOut = {{16{rb0[7]}}, rb0, rb1};
        default: MDR_DataOut = 32'h0;
      endcase
    end
  end

  function automatic logic [31:0] bd_read(input int a);
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  // ---------------- checking ----------------
  typedef struct packed { logic err; logic [63:0] rd; } exp_t;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  int         en_cycles = 0;
  int         en_rises  = 0;
  logic       busy_seen = 1'b0;
  logic       prev_en   = 1'b0;
  logic [5:0] first_op  = '0;

  always @(negedge Clk) begin
    exp_t e;
    if (Done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got Done=1 Err=%0b, expected no completion", Err);
      end else begin
        e = exp_q.pop_front();
        check("done_err", 128'(Err), 128'(e.err));
        check("done_rddata", 128'(RdData), 128'(e.rd));
      end
    end
    if (Enable) en_cycles++;
    if (Enable && !prev_en) begin
      if (en_rises == 0) first_op = OpCode;
      en_rises++;
    end
    prev_en = Enable;
    if (Busy) busy_seen = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic clear_mon();
    en_cycles = 0;
    en_rises  = 0;
    busy_seen = 1'b0;
  endtask

  task automatic bd_write(input logic [8:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    step();
    bd_we   = 1'b0;
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 1;
    while (!Done && lat < 40) begin
      step();
      lat++;
    end
    if (!Done) begin
      n_checks++;
      $display("FAIL %s_no_done: got no Done after %0d cycles, expected Done", name, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic issue(input string name, input logic [5:0] op, input logic [31:0] a,
                       input logic [63:0] wd, input logic e_err, input logic [63:0] e_rd,
                       output int lat);
    clear_mon();
    Op = op; Addr = a; WrData = wd; Req = 1'b1;
    exp_q.push_back({e_err, e_rd});
    step();
    Req = 1'b0;
    wait_done(name, lat);
  endtask

  int lat;

  initial begin
    // Reset state
    Reset = 1'b1;
    repeat (3) step();
    check("reset_ctrl", 128'({Enable, Busy, Done, Err, OpCode}), 128'(0));
    check("reset_bus", 128'({MAR_Address, MDR_DataIn}), 128'(0));
    check("reset_rddata", 128'(RdData), 128'(0));
    Reset = 1'b0;
    step();

    // Load word
    bd_write(9'h010, 32'h1234_5678);
    issue("ld", c_LD, 32'h10, 64'h0, 1'b0, 64'h0000_0000_1234_5678, lat);
    check("ld_latency", 128'(lat), 128'(2));
    check("ld_enable_cycles", 128'(en_cycles), 128'(1));
    check("ld_opcode", 128'(first_op), 128'(c_LD));

    // STD then LDD
    issue("std", c_STD, 32'h20, 64'hAABB_CCDD_1122_3344, 1'b0, 64'h0000_0000_1234_5678, lat);
    check("std_latency", 128'(lat), 128'(4));
    check("std_enable_rises", 128'(en_rises), 128'(2));
    check("std_ram_w0", 128'(bd_read(32'h20)), 128'(32'hAABB_CCDD));
    check("std_ram_w1", 128'(bd_read(32'h24)), 128'(32'h1122_3344));
    issue("ldd", c_LDD, 32'h20, 64'h0, 1'b0, 64'hAABB_CCDD_1122_3344, lat);

    // SWAP
    bd_write(9'h040, 32'hDEAD_BEEF);
    issue("swap", c_SWAP, 32'h40, 64'h0000_0000_0000_CAFE, 1'b0, 64'h0000_0000_DEAD_BEEF, lat);
    check("swap_enable_rises", 128'(en_rises), 128'(2));
    check("swap_ram", 128'(bd_read(32'h40)), 128'(32'h0000_CAFE));

    // Rejections
    issue("rej_align", c_LDUH, 32'h11, 64'h0, 1'b1, 64'h0000_0000_DEAD_BEEF, lat);
    check("rej_latency", 128'(lat), 128'(1));
    check("rej_no_enable", 128'(en_rises), 128'(0));
    check("rej_no_busy", 128'(busy_seen), 128'(0));
    issue("rej_ld_1fe", c_LD, 32'h1FE, 64'h0, 1'b1, 64'h0000_0000_DEAD_BEEF, lat);
    issue("rej_ldd_1fc", c_LDD, 32'h1FC, 64'h0, 1'b1, 64'h0000_0000_DEAD_BEEF, lat);
    issue("rej_illegal", c_BAD, 32'h0, 64'h0, 1'b1, 64'h0000_0000_DEAD_BEEF, lat);
    issue("rej_ld_range", c_LD, 32'h200, 64'h0, 1'b1, 64'h0000_0000_DEAD_BEEF, lat);

    // Last bytes of RAM are in range; sub-word loads extend correctly
    bd_write(9'h1FC, 32'h0102_A5B6);
    issue("ldub_1ff", c_LDUB, 32'h1FF, 64'h0, 1'b0, 64'h0000_0000_0000_00B6, lat);
    issue("ldsb_1ff", c_LDSB, 32'h1FF, 64'h0, 1'b0, 64'h0000_0000_FFFF_FFB6, lat);
    issue("ldsh_1fe", c_LDSH, 32'h1FE, 64'h0, 1'b0, 64'h0000_0000_FFFF_A5B6, lat);

    // Slow RAM
    ram_lat = 3;
    issue("ld_slow", c_LD, 32'h40, 64'h0, 1'b0, 64'h0000_0000_0000_CAFE, lat);
    check("ld_slow_enable_cycles", 128'(en_cycles), 128'(4));
    ram_lat = 0;

    // Timeout
    mfc_tie0 = 1'b1;
    issue("timeout", c_LD, 32'h10, 64'h0, 1'b1, 64'h0000_0000_0000_CAFE, lat);
    check("timeout_enable_cycles", 128'(en_cycles), 128'(MFC_TIMEOUT));
    check("timeout_latency", 128'(lat), 128'(MFC_TIMEOUT + 1));
    mfc_tie0 = 1'b0;
    step();

    // Reset during LDD phase 1
    ram_lat = 6;
    clear_mon();
    Op = c_LDD; Addr = 32'h20; Req = 1'b1;
    step();
    Req = 1'b0;
    for (int i = 0; i < 40 && en_rises < 2; i++) step();
    check("rst_mid_phase1_reached", 128'(en_rises), 128'(2));
    Reset = 1'b1;
    step();
    check("rst_mid_ctrl", 128'({Enable, Busy, Done, Err, OpCode}), 128'(0));
    check("rst_mid_bus", 128'({MAR_Address, MDR_DataIn}), 128'(0));
    check("rst_mid_rddata", 128'(RdData), 128'(0));
    Reset = 1'b0;
    ram_lat = 0;
    repeat (3) step();

    // Req held across Done: second request accepted in the Done cycle
    Op = c_LD; Addr = 32'h10; Req = 1'b1;
    exp_q.push_back({1'b0, 64'h0000_0000_1234_5678});
    step();
    wait_done("b2b_first", lat);
    Addr = 32'h40;
    exp_q.push_back({1'b0, 64'h0000_0000_0000_CAFE});
    step();
    check("b2b_accept", 128'({Busy, Enable, MAR_Address}), 128'({1'b1, 1'b1, 32'h40}));
    Req = 1'b0;
    wait_done("b2b_second", lat);

    // Req pulsed while busy is ignored
    ram_lat = 3;
    clear_mon();
    Op = c_LD; Addr = 32'h10; Req = 1'b1;
    exp_q.push_back({1'b0, 64'h0000_0000_1234_5678});
    step();
    Req = 1'b0;
    step();
    Op = c_ST; Addr = 32'h10; WrData = 64'hFFFF_FFFF_FFFF_FFFF; Req = 1'b1;
    step();
    Req = 1'b0;
    wait_done("busy_ld", lat);
    repeat (4) step();
    check("busy_req_rises", 128'(en_rises), 128'(1));
    check("busy_req_ram", 128'(bd_read(32'h10)), 128'(32'h1234_5678));
    check("busy_req_idle", 128'(Busy), 128'(0));
    ram_lat = 0;

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
